result_accumulator: RTL and testbench
=====================================

// Module: result_accumulator
// PURPOSE
//  Read-modify-write client of the dual-port result RAM: accepts (addr, partial-sum) pairs from the sparse
//  MAC array and adds each into result RAM entry addr. Port 0 reads, port 1 writes. On drain_start, streams
//  every entry out (addr 0..MEM_SIZE-1) over a valid/ready interface and zeroes it for the next tile.
// PARAMETERS
//  DWIDTH    32  data width of RAM words, partial sums and output
//  AWIDTH    4   RAM address width
//  MEM_SIZE  16  number of RAM entries, <= 2**AWIDTH; drain covers 0..MEM_SIZE-1
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       partial-sum beat valid
//  in_ready     out  1       accepting beats (1 only in ACC state)
//  in_addr      in   AWIDTH  target entry
//  in_data      in   DWIDTH  signed partial sum
//  drain_start  in   1       pulse: begin flush + drain; ignored unless state==ACC
//  busy         out  1       state != ACC or pipeline non-empty
//  drain_done   out  1       one-cycle pulse after last entry written zero
//  out_valid    out  1       drained word valid
//  out_ready    in   1       consumer accepts drained word
//  out_addr     out  AWIDTH  address of drained word
//  out_data     out  DWIDTH  drained word
//  ram_addr0    out  AWIDTH  RAM port 0 address
//  ram_ce0      out  1       RAM port 0 enable
//  ram_we0      out  1       tied 0 (port 0 read-only)
//  ram_d0       out  DWIDTH  tied 0
//  ram_q0       in   DWIDTH  RAM port 0 read data, valid 1 cycle after ce0 & !we0
//  ram_addr1    out  AWIDTH  RAM port 1 address
//  ram_ce1      out  1       RAM port 1 enable
//  ram_we1      out  1       RAM port 1 write enable (always = ce1)
//  ram_d1       out  DWIDTH  RAM port 1 write data
// BEHAVIOUR
//  Reset: state=ACC, all valids/ce/we/pulses 0, out_addr/out_data/addresses 0, pipeline and fwd regs cleared.
//  Accumulate pipeline (ACC state, in_ready=1, one beat per cycle, no stalls):
//   - cycle t: beat accepted when in_valid&in_ready; drive ce0=1, addr0=in_addr; latch {v1,a1,d1}.
//   - cycle t+1 (v1): sum = base + d1; drive ce1=we1=1, addr1=a1, d1=sum; write commits at end of t+1.
//   - base = fwd_data if fwd_hit else ram_q0. fwd_hit latched at t: in_addr==a1 while v1 (stage-1 write in
//     same edge as read -> RAM returns stale). fwd_data = sum written in cycle t.
//   - same addr every cycle for N cycles -> final entry = old + sum of all N beats. Addr two beats apart needs
//     no forwarding (write committed before read edge).
//   - arithmetic: two's complement, modulo 2**DWIDTH, no saturation, no overflow flag.
//  FSM: ACC -> FLUSH on drain_start (in_ready drops same cycle; beat presented that cycle NOT accepted).
//   FLUSH: wait until v1==0 (<=1 cycle) -> DRD with idx=0.
//   DRD:  ce0=1, addr0=idx -> DCAP.
//   DCAP: out_data<=ram_q0, out_addr<=idx, out_valid<=1 -> DOUT.
//   DOUT: hold out_* stable while out_valid & !out_ready. On handshake: out_valid<=0, ce1=we1=1,
//         addr1=idx, d1=0; if idx==MEM_SIZE-1 -> DONE else idx++ -> DRD.
//   DONE: drain_done=1 one cycle -> ACC.
//  Min 3 cycles per drained word. drain_start during FLUSH/DRD/DCAP/DOUT/DONE ignored.
//  Port 0 and port 1 never target the same address for write in one cycle (port 0 never writes).
//  Reset mid-drain or mid-accumulate: state lost immediately; RAM contents undefined for caller (partial
//   drain); caller must re-issue tile. No RAM access while rst_n low.
// STRUCTURE
//  Shared package: state encoding (ACC, FLUSH, DRD, DCAP, DOUT, DONE), default DWIDTH/AWIDTH/MEM_SIZE.
//  One natural sub-module: result_acc_fwd (stage-1 regs, hazard compare, forward mux, adder).
//  FSM + drain index + output register in top. Bench instantiates with result RAM model (registered q).
// TESTING
//  1. Fresh RAM=0; beats (3,5),(7,-2),(3,10) non-consecutive gaps -> drain yields addr3=15, addr7=-2, others 0.
//  2. Back-to-back same addr: (4,1),(4,2),(4,3),(4,4) on 4 consecutive cycles -> entry4=10 (forwarding).
//  3. Alternating (2,1),(9,1),(2,1),(9,1) consecutive -> entry2=2, entry9=2; overflow: (0,0xFFFFFFFF),(0,2) -> 1.
//  4. Drain with out_ready low 5 cycles on word 6 -> out_* stable; 16 words addr 0..15 in order; drain_done
//     once; second drain returns all zeros.
//  5. drain_start same cycle as in_valid -> beat not accepted, in_ready=0; drain_start in DOUT ignored.
//  6. rst_n asserted during DOUT -> next cycle out_valid=0, ce0=ce1=0, in_ready=1 after release, busy=0.

Source files
------------

// File: rtl/result_accumulator_pkg.sv
// Shared definitions for the result accumulator: FSM state encoding and default sizes.
package result_accumulator_pkg;

    localparam int DEF_DWIDTH   = 32;
    localparam int DEF_AWIDTH   = 4;
    localparam int DEF_MEM_SIZE = 16;

    typedef enum logic [2:0] {
        ST_ACC   = 3'd0,
        ST_FLUSH = 3'd1,
        ST_DRD   = 3'd2,
        ST_DCAP  = 3'd3,
        ST_DOUT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/result_acc_fwd.sv
// Stage-1 of the read-modify-write pipeline: holds the accepted beat, detects the
// read-after-write hazard on back-to-back beats to one entry, and forms the new sum.
module result_acc_fwd #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [DWIDTH-1:0] rd_data,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data
);

    logic              v1_r;
    logic [AWIDTH-1:0] a1_r;
    logic [DWIDTH-1:0] d1_r;
    logic              hit_r;
    logic [DWIDTH-1:0] fwd_data_r;
    logic [DWIDTH-1:0] base_s;
    logic [DWIDTH-1:0] sum_s;

    // Base selection and modulo add; the RAM read is stale when the previous beat wrote the same entry
    always_comb begin
        base_s = hit_r ? fwd_data_r : rd_data;
        sum_s  = base_s + d1_r;
    end

    // Stage-1 registers, hazard flag and forwarded sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r       <= 1'b0;
            a1_r       <= {AWIDTH{1'b0}};
            d1_r       <= {DWIDTH{1'b0}};
            hit_r      <= 1'b0;
            fwd_data_r <= {DWIDTH{1'b0}};
        end else begin
            v1_r       <= accept;
            hit_r      <= accept & v1_r & (in_addr == a1_r);
            fwd_data_r <= sum_s;
            if (accept) begin
                a1_r <= in_addr;
                d1_r <= in_data;
            end else begin
                a1_r <= a1_r;
                d1_r <= d1_r;
            end
        end
    end

    assign wr_en   = v1_r;
    assign wr_addr = a1_r;
    assign wr_data = sum_s;

endmodule

// File: rtl/result_accumulator.sv
// Accumulates (addr, partial-sum) beats into the result RAM and, on request,
// streams every entry out over valid/ready while zeroing it for the next tile.
module result_accumulator
    import result_accumulator_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              drain_start,
    output logic              busy,
    output logic              drain_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_addr,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH-1:0] ram_addr0,
    output logic              ram_ce0,
    output logic              ram_we0,
    output logic [DWIDTH-1:0] ram_d0,
    input  logic [DWIDTH-1:0] ram_q0,
    output logic [AWIDTH-1:0] ram_addr1,
    output logic              ram_ce1,
    output logic              ram_we1,
    output logic [DWIDTH-1:0] ram_d1
);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(MEM_SIZE - 1);
    localparam logic [AWIDTH-1:0] IDX_ONE  = AWIDTH'(1);

    state_t            state_r;
    state_t            state_nx_s;
    logic [AWIDTH-1:0] idx_r;
    logic              idx_clr_s;
    logic              cap_s;
    logic              hs_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [AWIDTH-1:0] wr_addr_s;
    logic [DWIDTH-1:0] wr_data_s;
    logic              out_valid_r;
    logic [AWIDTH-1:0] out_addr_r;
    logic [DWIDTH-1:0] out_data_r;

    // in_ready drops in the drain_start cycle so that beat is refused; gated off while in reset
    assign in_ready = rst_n & (state_r == ST_ACC) & ~drain_start;
    assign accept_s = in_valid & in_ready;

    result_acc_fwd #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_fwd (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (accept_s),
        .in_addr (in_addr),
        .in_data (in_data),
        .rd_data (ram_q0),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and per-cycle drain strobes
    always_comb begin
        state_nx_s = state_r;
        idx_clr_s  = 1'b0;
        cap_s      = 1'b0;
        hs_s       = 1'b0;
        case (state_r)
            ST_ACC: begin
                if (drain_start) state_nx_s = ST_FLUSH;
                else             state_nx_s = ST_ACC;
            end
            ST_FLUSH: begin
                if (!wr_en_s) begin
                    state_nx_s = ST_DRD;
                    idx_clr_s  = 1'b1;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_DRD:  state_nx_s = ST_DCAP;
            ST_DCAP: begin
                state_nx_s = ST_DOUT;
                cap_s      = 1'b1;
            end
            ST_DOUT: begin
                if (out_valid_r && out_ready) begin
                    hs_s = 1'b1;
                    if (idx_r == LAST_IDX) state_nx_s = ST_DONE;
                    else                   state_nx_s = ST_DRD;
                end else begin
                    state_nx_s = ST_DOUT;
                end
            end
            ST_DONE: state_nx_s = ST_ACC;
            default: state_nx_s = ST_ACC;
        endcase
    end

    // Drain index and held output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {AWIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_addr_r  <= {AWIDTH{1'b0}};
            out_data_r  <= {DWIDTH{1'b0}};
        end else begin
            if (idx_clr_s)  idx_r <= {AWIDTH{1'b0}};
            else if (hs_s)  idx_r <= idx_r + IDX_ONE;
            else            idx_r <= idx_r;
            if (cap_s) begin
                out_valid_r <= 1'b1;
                out_addr_r  <= idx_r;
                out_data_r  <= ram_q0;
            end else if (hs_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // RAM ports: accumulate writes and drain zeroing never overlap since FLUSH empties stage 1 first
    always_comb begin
        ram_ce0   = accept_s | (state_r == ST_DRD);
        ram_addr0 = {AWIDTH{1'b0}};
        if (accept_s)                ram_addr0 = in_addr;
        else if (state_r == ST_DRD)  ram_addr0 = idx_r;
        else                         ram_addr0 = {AWIDTH{1'b0}};
        ram_ce1   = wr_en_s | hs_s;
        ram_addr1 = {AWIDTH{1'b0}};
        ram_d1    = {DWIDTH{1'b0}};
        if (wr_en_s) begin
            ram_addr1 = wr_addr_s;
            ram_d1    = wr_data_s;
        end else if (hs_s) begin
            ram_addr1 = idx_r;
        end else begin
            ram_addr1 = {AWIDTH{1'b0}};
        end
    end

    assign ram_we0    = 1'b0;
    assign ram_d0     = {DWIDTH{1'b0}};
    assign ram_we1    = ram_ce1;
    assign busy       = (state_r != ST_ACC) | wr_en_s;
    assign drain_done = (state_r == ST_DONE);
    assign out_valid  = out_valid_r;
    assign out_addr   = out_addr_r;
    assign out_data   = out_data_r;

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: registered-q RAM model plus a per-entry reference
// array updated with plain modular addition for every beat the bench offers.
module tb_result_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_start;
    logic        busy;
    logic        drain_done;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_addr;
    logic [31:0] out_data;
    logic [3:0]  ram_addr0;
    logic        ram_ce0;
    logic        ram_we0;
    logic [31:0] ram_d0;
    logic [31:0] ram_q0 = 32'd0;
    logic [3:0]  ram_addr1;
    logic        ram_ce1;
    logic        ram_we1;
    logic [31:0] ram_d1;

    logic [31:0] mem [16] = '{default: 32'd0};
    logic [31:0] ref_mem [16];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;

    result_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_start(drain_start),
        .busy(busy), .drain_done(drain_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .ram_addr0(ram_addr0), .ram_ce0(ram_ce0), .ram_we0(ram_we0),
        .ram_d0(ram_d0), .ram_q0(ram_q0), .ram_addr1(ram_addr1),
        .ram_ce1(ram_ce1), .ram_we1(ram_we1), .ram_d1(ram_d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result RAM: read data registered, write commits at the edge
    always @(posedge clk) begin
        if (ram_ce0 && !ram_we0) ram_q0 <= mem[ram_addr0];
        if (ram_ce1 && ram_we1)  mem[ram_addr1] <= ram_d1;
    end

    always @(posedge clk) begin
        if (drain_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        #1;
        check_val("in_ready_beat", {31'd0, in_ready}, 32'd1);
        ref_mem[a] = ref_mem[a] + d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full drain; optional stall, drain_start during DOUT, or reset during DOUT (99 = none)
    task automatic run_drain(input int stall_word, input int ds_word, input int rst_word);
        int base_done;
        int waitc;
        base_done   = done_cnt;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        in_valid    = 1'b0;
        for (int w = 0; w < 16; w++) begin
            waitc = 0;
            while (!out_valid && waitc < 20) begin
                tick();
                waitc++;
            end
            check_val("drain_wait", {31'd0, out_valid}, 32'd1);
            check_val("drain_addr", {28'd0, out_addr}, 32'(w));
            check_val("drain_data", out_data, ref_mem[w]);
            if (w == rst_word) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_addr   = 4'd1;
                rst_n     = 1'b0;
                #1;
                check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
                check_val("rst_ce0", {31'd0, ram_ce0}, 32'd0);
                check_val("rst_ce1", {31'd0, ram_ce1}, 32'd0);
                tick();
                check_val("rst_ce0_next", {31'd0, ram_ce0}, 32'd0);
                check_val("rst_ce1_next", {31'd0, ram_ce1}, 32'd0);
                in_valid  = 1'b0;
                out_ready = 1'b1;
                rst_n     = 1'b1;
                tick();
                check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
                check_val("rst_busy", {31'd0, busy}, 32'd0);
                check_val("rst_out_valid_after", {31'd0, out_valid}, 32'd0);
                return;
            end
            if (w == stall_word) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check_val("stall_valid", {31'd0, out_valid}, 32'd1);
                    check_val("stall_addr", {28'd0, out_addr}, 32'(w));
                    check_val("stall_data", out_data, ref_mem[w]);
                end
                out_ready = 1'b1;
            end
            if (w == ds_word) drain_start = 1'b1;
            tick();
            drain_start = 1'b0;
            ref_mem[w] = 32'd0;
        end
        repeat (3) tick();
        check_val("drain_done_once", 32'(done_cnt - base_done), 32'd1);
        check_val("busy_after_drain", {31'd0, busy}, 32'd0);
        check_val("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] ra;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_addr     = 4'd0;
        in_data     = 32'd0;
        drain_start = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_drain_done", {31'd0, drain_done}, 32'd0);
        check_val("reset_out_addr", {28'd0, out_addr}, 32'd0);
        check_val("reset_out_data", out_data, 32'd0);
        check_val("reset_ce0", {31'd0, ram_ce0}, 32'd0);
        check_val("reset_ce1", {31'd0, ram_ce1}, 32'd0);
        tick();

        // Sparse beats with gaps
        beat(4'd3, 32'd5);
        repeat (2) tick();
        beat(4'd7, 32'hFFFF_FFFE);
        repeat (3) tick();
        beat(4'd3, 32'd10);
        repeat (2) tick();
        run_drain(99, 99, 99);

        // Back-to-back same entry, alternating entries, and wrap-around
        beat(4'd4, 32'd1);
        beat(4'd4, 32'd2);
        beat(4'd4, 32'd3);
        beat(4'd4, 32'd4);
        beat(4'd2, 32'd1);
        beat(4'd9, 32'd1);
        beat(4'd2, 32'd1);
        beat(4'd9, 32'd1);
        beat(4'd0, 32'hFFFF_FFFF);
        beat(4'd0, 32'd2);
        repeat (2) tick();
        run_drain(6, 99, 99);
        run_drain(99, 99, 99);

        // Beat offered together with drain_start must be refused
        beat(4'd5, 32'd7);
        in_valid    = 1'b1;
        in_addr     = 4'd5;
        in_data     = 32'd100;
        drain_start = 1'b1;
        #1;
        check_val("ds_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("ds_ce0", {31'd0, ram_ce0}, 32'd0);
        run_drain(99, 2, 99);

        // Random beats with runs on one entry, then a reset mid-drain
        ra = 4'd0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) != 0) ra = 4'($urandom_range(0, 15));
            beat(ra, $urandom);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 2)) tick();
        end
        repeat (2) tick();
        run_drain(99, 99, 3);
        for (int i = 0; i < 3; i++) ref_mem[i] = 32'd0;
        run_drain(99, 99, 99);
        run_drain(99, 99, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
